// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_pkg
// Description : Shared constants and helpers for the multi-flop synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

  // Legal synchronizer depth range. Two flops is the minimum that gives a
  // metastable first stage a full clock period to resolve.
  localparam int MIN_STAGES     = 2;
  localparam int MAX_STAGES     = 8;

  // Default configuration: single-bit, classic two-flop synchronizer.
  localparam int DEFAULT_WIDTH  = 1;
  localparam int DEFAULT_STAGES = 2;

  // True when a requested chain depth is within the supported range.
  function automatic bit stages_legal(input int n);
    return (n >= MIN_STAGES) && (n <= MAX_STAGES);
  endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_stage_chain
// Description : WIDTH-wide cascade of STAGES flops with synchronous
//               active-low reset. Each bit is synchronized independently.
//               Only stage 0 samples the foreign-domain input, and only
//               stage 1 ever reads stage 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_stage_chain
  import sync_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               STAGES    = DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Every stage carries the synchronizer attributes so the tools keep the
  // flops adjacent, never retime or merge them, and treat stage 0 as a
  // metastability capture point.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift d through the chain; reset overrides d and loads every stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule : sync_stage_chain
`default_nettype wire

// File: rtl/two_dff_sync.sv
`default_nettype none
// ============================================================================
// Module      : two_dff_sync
// Description : Multi-flop synchronizer bringing an asynchronous signal into
//               the clock domain, plus per-bit rise/fall pulses derived from
//               the synchronized output. Edge pulses are combinational from
//               registered state only, so they cannot glitch on d.
// Revision    : 1.0 - initial release
// ============================================================================
module two_dff_sync
  import sync_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               STAGES    = DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Reject out-of-range chain depths at elaboration.
  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("two_dff_sync: STAGES=%0d outside legal range %0d..%0d",
           STAGES, MIN_STAGES, MAX_STAGES);
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] r_q_prev;

  sync_stage_chain #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_chain (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_d     (d),
    .o_q     (w_q)
  );

  // History of the synchronized output; reset to the same value as the
  // chain so no edge pulse can appear at or just after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q_prev <= RESET_VAL;
    end else begin
      r_q_prev <= w_q;
    end
  end

  assign q2   = w_q;
  assign rise =  w_q & ~r_q_prev;
  assign fall = ~w_q &  r_q_prev;

endmodule : two_dff_sync
`default_nettype wire

// File: tb/tb_two_dff_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_two_dff_sync
// Description : Self-checking bench for two_dff_sync. Two instances: the
//               default 1-bit/2-stage synchronizer and a 4-bit/3-stage one
//               with a non-zero reset value. Directed table, a sub-cycle
//               pulse sequence, then random stimulus against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_two_dff_sync;

  localparam int         S_A  = 2;
  localparam int         S_B  = 3;
  localparam logic [3:0] RV_A = 4'h0;
  localparam logic [3:0] RV_B = 4'h5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       d_a   = 1'b0;
  logic [3:0] d_b   = 4'h0;
  logic       q2_a, rise_a, fall_a;
  logic [3:0] q2_b, rise_b, fall_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-edge record of what each instance sampled.
  bit         h_rst[$];
  logic [3:0] h_da[$];
  logic [3:0] h_db[$];

  two_dff_sync dut_a (
    .clock (clock), .reset (reset), .d (d_a),
    .q2 (q2_a), .rise (rise_a), .fall (fall_a)
  );

  two_dff_sync #(.WIDTH(4), .STAGES(S_B), .RESET_VAL(RV_B)) dut_b (
    .clock (clock), .reset (reset), .d (d_b),
    .q2 (q2_b), .rise (rise_b), .fall (fall_b)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       rst;
    logic       da;
    logic [3:0] db;
    logic       qa, ra, fa;
    logic [3:0] qb, rb, fb;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t row(input logic rst, input logic da, input logic [3:0] db,
                               input logic qa, input logic ra, input logic fa,
                               input logic [3:0] qb, input logic [3:0] rb,
                               input logic [3:0] fb);
    vec_t v;
    v.rst = rst; v.da = da; v.db = db;
    v.qa = qa; v.ra = ra; v.fa = fa;
    v.qb = qb; v.rb = rb; v.fb = fb;
    return v;
  endfunction

  // Output after edge n: the d seen STAGES-1 edges earlier, unless any edge
  // in that window (or before time began) was a reset edge.
  function automatic logic [3:0] mdl_q(input int n, input int stg,
                                       input logic [3:0] rv, input bit sel_b);
    int src = n - stg + 1;
    if (src < 0) return rv;
    for (int k = src; k <= n; k++) begin
      if (!h_rst[k]) return rv;
    end
    return sel_b ? h_db[src] : h_da[src];
  endfunction

  // Previous-output history after edge n.
  function automatic logic [3:0] mdl_prev(input int n, input int stg,
                                          input logic [3:0] rv, input bit sel_b);
    if (n < 0) return rv;
    if (!h_rst[n]) return rv;
    return mdl_q(n - 1, stg, rv, sel_b);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    h_rst.push_back(reset);
    h_da.push_back({3'b000, d_a});
    h_db.push_back(d_b);
    #1;
    cyc++;
  endtask

  task automatic check_model();
    int n = h_rst.size() - 1;
    logic [3:0] qa, pa, qb, pb;
    qa = mdl_q(n, S_A, RV_A, 1'b0);
    pa = mdl_prev(n, S_A, RV_A, 1'b0);
    qb = mdl_q(n, S_B, RV_B, 1'b1);
    pb = mdl_prev(n, S_B, RV_B, 1'b1);
    chk("rnd_q_a",    {3'b000, q2_a},   qa);
    chk("rnd_rise_a", {3'b000, rise_a}, qa & ~pa);
    chk("rnd_fall_a", {3'b000, fall_a}, ~qa & pa);
    chk("rnd_q_b",    q2_b,   qb);
    chk("rnd_rise_b", rise_b, qb & ~pb);
    chk("rnd_fall_b", fall_b, ~qb & pb);
  endtask

  initial begin
    //               rst  da   db     qa   ra   fa   qb     rb     fb
    tbl[0]  = row(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0);
    tbl[1]  = row(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0);
    tbl[2]  = row(1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0);
    tbl[3]  = row(1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0);
    tbl[4]  = row(1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'hA, 4'hA, 4'h5);
    tbl[5]  = row(1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0);
    tbl[6]  = row(1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0);
    tbl[7]  = row(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h0, 4'h0);
    tbl[8]  = row(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0);
    tbl[9]  = row(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hA);
    tbl[10] = row(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[11] = row(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    tbl[12] = row(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0);
    tbl[13] = row(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0);
    tbl[14] = row(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 4'h5, 4'h0, 4'h0);
    tbl[15] = row(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 4'hA, 4'h0);
    tbl[16] = row(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0);

    // Directed table: reset, latency, rise/fall pulses, mid-stream reset.
    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst;
      d_a   = tbl[i].da;
      d_b   = tbl[i].db;
      tick();
      chk($sformatf("row%0d_q_a", i),    {3'b000, q2_a},   {3'b000, tbl[i].qa});
      chk($sformatf("row%0d_rise_a", i), {3'b000, rise_a}, {3'b000, tbl[i].ra});
      chk($sformatf("row%0d_fall_a", i), {3'b000, fall_a}, {3'b000, tbl[i].fa});
      chk($sformatf("row%0d_q_b", i),    q2_b,   tbl[i].qb);
      chk($sformatf("row%0d_rise_b", i), rise_b, tbl[i].rb);
      chk($sformatf("row%0d_fall_b", i), fall_b, tbl[i].fb);
    end

    // A d pulse that opens and closes between two edges is never sampled.
    reset = 1'b1;
    d_a   = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      d_a = 1'b1;
      #3;
      d_a = 1'b0;
      tick();
      chk($sformatf("glitch%0d_q_a", i),    {3'b000, q2_a},   4'h0);
      chk($sformatf("glitch%0d_rise_a", i), {3'b000, rise_a}, 4'h0);
    end

    // Random data with occasional reset edges, checked against the model.
    for (int i = 0; i < 200; i++) begin
      reset = ($urandom_range(0, 24) != 0);
      d_a   = 1'($urandom_range(0, 1));
      d_b   = 4'($urandom_range(0, 15));
      tick();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_two_dff_sync
`default_nettype wire
